gpu_rect_sender: RTL

- Transmit end of the GPU rectangle-load interface; drives the gpu_receiver_fsm control tuple and data word.
- On each frame start, walks all rectangles in data memory in batches of 16. Streams them field by field (X, WIDTH, Y, HEIGHT, COLOR) with the matching coordinate sweeps. Pulses done when the last write has left the receiver pipeline.
- Sits between data memory (sync RAM, 1-cycle read) and gpu_receiver_fsm.

---
 rtl/gpu_pkg.sv | 50 +++++
 rtl/gpu_sender_delay.sv | 35 +++
 rtl/gpu_rect_sender.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU rectangle sender: field phases, field offsets
// within a rectangle record, and batch geometry.
package gpu_pkg;

  typedef enum logic [2:0] {
    WAIT_FOR_START = 3'd0,
    READ_X         = 3'd1,
    READ_WIDTH     = 3'd2,
    READ_Y         = 3'd3,
    READ_HEIGHT    = 3'd4,
    READ_COLOR     = 3'd5
  } gpu_state_e;

  localparam int unsigned RECTS_PER_BATCH = 16;
  localparam int unsigned FIELDS_PER_RECT = 5;

  localparam int unsigned FIELD_X      = 0;
  localparam int unsigned FIELD_WIDTH  = 1;
  localparam int unsigned FIELD_Y      = 2;
  localparam int unsigned FIELD_HEIGHT = 3;
  localparam int unsigned FIELD_COLOR  = 4;

  function automatic logic [2:0] field_offset(input gpu_state_e s);
    logic [2:0] off;
    off = '0;
    case (s)
      READ_X:      off = 3'(FIELD_X);
      READ_WIDTH:  off = 3'(FIELD_WIDTH);
      READ_Y:      off = 3'(FIELD_Y);
      READ_HEIGHT: off = 3'(FIELD_HEIGHT);
      READ_COLOR:  off = 3'(FIELD_COLOR);
      default:     off = '0;
    endcase
    return off;
  endfunction

  function automatic gpu_state_e next_field(input gpu_state_e s);
    gpu_state_e n;
    n = WAIT_FOR_START;
    case (s)
      READ_X:      n = READ_WIDTH;
      READ_WIDTH:  n = READ_Y;
      READ_Y:      n = READ_HEIGHT;
      READ_HEIGHT: n = READ_COLOR;
      default:     n = WAIT_FOR_START;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/gpu_sender_delay.sv
// Fixed-depth data pipeline with synchronous clear; aligns memory read data
// with the receiver's control-tuple delay.
module gpu_sender_delay #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [STAGES];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int unsigned i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else if (clr_i) begin
          for (int unsigned i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int unsigned i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/gpu_rect_sender.sv
// Transmit side of the GPU rectangle-load interface: walks all rectangles in
// batches of 16, field by field. Optional abort input via GPU_SENDER_ABORT_EN.
module gpu_rect_sender
  import gpu_pkg::*;
#(
  parameter int unsigned COORD_WIDTH = 10,
  parameter int unsigned RECT_COUNT  = 64,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DIN_LAG     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef GPU_SENDER_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [15:0]            mem_data,
  output logic [2:0]             state,
  output logic [COORD_WIDTH-1:0] coord_generator,
  output logic [3:0]             rect_counter,
  output logic [1:0]             batch_counter,
  output logic                   batch_completed,
  output logic [15:0]            din,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned NUM_BATCHES = RECT_COUNT / RECTS_PER_BATCH;
  localparam logic [1:0] LAST_BATCH = 2'(NUM_BATCHES - 1);
  localparam logic [3:0] LAST_RECT  = 4'(RECTS_PER_BATCH - 1);
  localparam logic [COORD_WIDTH-1:0] W_LAST = COORD_WIDTH'(SCREEN_W - 1);
  localparam logic [COORD_WIDTH-1:0] H_LAST = COORD_WIDTH'(SCREEN_H - 1);
  localparam logic [ADDR_WIDTH-1:0] RECT_STRIDE  = ADDR_WIDTH'(FIELDS_PER_RECT);
  localparam logic [ADDR_WIDTH-1:0] BATCH_STRIDE = ADDR_WIDTH'(FIELDS_PER_RECT * RECTS_PER_BATCH);
  localparam int unsigned DRAIN_W = (DIN_LAG > 1) ? $clog2(DIN_LAG) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DIN_LAG - 1);

  gpu_state_e             state_q;
  logic                   bc_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   draining_q;
  logic                   valid_q;
  logic [3:0]             rect_q;
  logic [1:0]             batch_q;
  logic [COORD_WIDTH-1:0] coord_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  batch_base_q;
  logic [DRAIN_W-1:0]     drain_q;

  logic [COORD_WIDTH-1:0] sweep_last;
  logic                   rd_tuple;
  logic                   flush;
  logic [15:0]            pipe_in;

`ifdef GPU_SENDER_ABORT_EN
  assign flush = abort && busy_q;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    sweep_last = H_LAST;
    if (state_q == READ_X || state_q == READ_WIDTH) sweep_last = W_LAST;
  end

  // Only load-phase and colour tuples issue real reads; sweep tuples carry 0.
  assign rd_tuple = (state_q != WAIT_FOR_START) && (!bc_q || state_q == READ_COLOR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT_FOR_START;
      bc_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      draining_q   <= 1'b0;
      rect_q       <= '0;
      batch_q      <= '0;
      coord_q      <= '0;
      addr_q       <= '0;
      batch_base_q <= '0;
      drain_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q    <= WAIT_FOR_START;
        bc_q       <= 1'b0;
        busy_q     <= 1'b0;
        draining_q <= 1'b0;
        rect_q     <= '0;
        batch_q    <= '0;
        coord_q    <= '0;
        drain_q    <= '0;
      end else if (!busy_q) begin
        // done_q blocks a start coinciding with the completion pulse.
        if (start && !done_q) begin
          busy_q       <= 1'b1;
          state_q      <= READ_X;
          bc_q         <= 1'b0;
          rect_q       <= '0;
          batch_q      <= '0;
          coord_q      <= '0;
          addr_q       <= base_addr;
          batch_base_q <= base_addr;
        end
      end else if (draining_q) begin
        if (drain_q == DRAIN_LAST) begin
          draining_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
        end else begin
          drain_q <= drain_q + 1'b1;
        end
      end else if (state_q == READ_COLOR) begin
        if (rect_q == LAST_RECT) begin
          rect_q  <= '0;
          coord_q <= '0;
          bc_q    <= 1'b0;
          if (batch_q != LAST_BATCH) begin
            batch_q      <= batch_q + 1'b1;
            batch_base_q <= batch_base_q + BATCH_STRIDE;
            addr_q       <= batch_base_q + BATCH_STRIDE;
            state_q      <= READ_X;
          end else begin
            batch_q    <= '0;
            state_q    <= WAIT_FOR_START;
            draining_q <= 1'b1;
            drain_q    <= '0;
          end
        end else begin
          rect_q  <= rect_q + 1'b1;
          coord_q <= coord_q + 1'b1;
          addr_q  <= addr_q + RECT_STRIDE;
        end
      end else if (!bc_q) begin
        if (rect_q == LAST_RECT) begin
          bc_q    <= 1'b1;
          rect_q  <= '0;
          coord_q <= '0;
        end else begin
          rect_q <= rect_q + 1'b1;
          addr_q <= addr_q + RECT_STRIDE;
        end
      end else begin
        if (coord_q == sweep_last) begin
          rect_q <= '0;
          if (state_q == READ_HEIGHT) begin
            state_q <= READ_COLOR;
            coord_q <= COORD_WIDTH'({batch_q, 4'b0000});
            addr_q  <= batch_base_q + ADDR_WIDTH'(FIELD_COLOR);
          end else begin
            state_q <= next_field(state_q);
            bc_q    <= 1'b0;
            coord_q <= '0;
            addr_q  <= batch_base_q + ADDR_WIDTH'(field_offset(next_field(state_q)));
          end
        end else begin
          coord_q <= coord_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= 1'b0;
    else if (flush) valid_q <= 1'b0;
    else valid_q <= rd_tuple;
  end

  assign pipe_in = valid_q ? mem_data : '0;

  gpu_sender_delay #(
    .WIDTH  (16),
    .STAGES (DIN_LAG - 1)
  ) u_delay (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (flush),
    .d_i    (pipe_in),
    .q_o    (din)
  );

  assign state           = state_q;
  assign batch_completed = bc_q;
  assign rect_counter    = rect_q;
  assign batch_counter   = batch_q;
  assign coord_generator = coord_q;
  assign mem_addr        = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
